led_scan_ctrl: RTL and testbench
================================

// Module: led_scan_ctrl
// PURPOSE
//  Scan controller for the 9-row x 8-column LED matrix. It owns a double-buffered
//  frame store: 2 banks x ROWS rows x 8 bits. Writers fill the back bank through a
//  row write port, and the block scans the front bank onto led_row/led_col with
//  inter-row blanking. Swaps are requested by the writer and happen only at a frame
//  boundary, so no frame is ever displayed half-updated.
// PARAMETERS
//  PERIOD  16'd27000  sys_clk cycles per row slot (1 ms @ 27 MHz); legal range 4..65535
//  GAP     16'd500    blanking cycles at each end of a row slot; must satisfy 2*GAP < PERIOD
//  ROWS    9          number of matrix rows, 2..9
// PORTS
//  sys_clk      in   1  system clock
//  rst_n        in   1  asynchronous active-low reset
//  wr_en        in   1  write row wr_row of the back bank this cycle
//  wr_row       in   4  row address, 0..ROWS-1; writes with wr_row>=ROWS are ignored
//  wr_data      in   8  column pattern; bit i drives led_col[i]
//  swap_req     in   1  1-cycle pulse: swap banks at the next frame boundary
//  swap_pending out  1  a swap is requested but not yet performed
//  swap_ack     out  1  1-cycle pulse: the swap has just taken effect
//  frame_start  out  1  1-cycle pulse aligned with the first output cycle of row 0
//  led_row      out  9  one-hot row drive (bits >= ROWS always 0)
//  led_col      out  8  column drive for the active row
// BEHAVIOUR
//  Reset: all outputs 0. cnt=0, row=0, front_sel=0, pending=0. Both banks cleared to 8'h00.
//  Counters:
//   - cnt counts 0..PERIOD-1 every cycle and wraps to 0.
//   - row advances when cnt==PERIOD-1; after ROWS-1 it wraps to 0.
//   - One frame = ROWS*PERIOD cycles.
//  Outputs are registered with 1-cycle latency: values at cycle t+1 reflect cnt/row at cycle t.
//   - led_row = (1<<row) when GAP <= cnt < PERIOD-GAP, else 0.
//   - led_col = bank[front_sel][row] for the whole slot, including blanking cycles.
//   - frame_start = 1 when cnt==0 && row==0.
//  Write port:
//   - On wr_en with wr_row<ROWS, bank[~front_sel][wr_row] <= wr_data at the clock edge.
//   - Only one write per cycle. A later write to the same row overwrites the earlier one.
//  Swap:
//   - Boundary cycle B = the cycle where cnt==PERIOD-1 && row==ROWS-1.
//   - swap_req sets pending. A swap_req while pending is already 1 has no further effect;
//     it is not counted.
//   - In cycle B, if (pending | swap_req): front_sel toggles, pending clears, and
//     swap_ack=1 in the following cycle. That cycle is the same one that shows
//     frame_start and row 0 of the new front bank.
//   - A swap_req arriving in cycle B is served at that same boundary.
//   - A wr_en in cycle B writes the pre-swap back bank, so it becomes visible in the
//     frame that starts next.
//   - No copy on swap: the new back bank keeps the old front contents.
//  swap_pending = pending (registered); it is 1 from the cycle after swap_req until
//   the cycle swap_ack is 1 (exclusive).
//  Reset mid-operation: everything returns to reset state immediately. Pending swaps and
//   both banks are lost. The scan restarts at row 0 with all LEDs off.
//  Widths: cnt is 16 bits; comparisons are unsigned; PERIOD-GAP is computed in 16 bits.
// TESTING  (PERIOD=20, GAP=3, ROWS=9 unless noted)
//  1. Reset release, no writes. Expect:
//     - led_row one-hot only for 14 cycles per 20-cycle slot (output cnt 3..16);
//     - rows cycle 0..8 and then 0;
//     - frame_start pulses every 180 cycles;
//     - led_col stays 0.
//  2. Write rows 0..8 = 8'h01..8'h09, then swap_req. Expect:
//     - swap_pending=1 until the boundary;
//     - swap_ack coincides with frame_start;
//     - led_col shows 8'h01..8'h09 in rows 0..8 of the next frame.
//  3. Write wr_row=9 and wr_row=15 with 8'hFF, then swap. Expect no row shows 8'hFF and
//     led_row[8:0] never has a bit >= ROWS set.
//  4. swap_req exactly in cycle B. Expect swap_ack on the very next cycle. A second
//     swap_req while pending yields exactly one swap and one swap_ack.
//  5. wr_en row 2 = 8'hA5 in cycle B together with a swap. Expect 8'hA5 shown in row 2
//     of the following frame, with the bank unchanged otherwise.
//  6. Assert rst_n low mid-frame while a swap is pending. Expect:
//     - outputs go to 0 immediately (asynchronously), with swap_pending=0;
//     - after release, the scan restarts at row 0 with led_col=0;
//     - no swap_ack.

Source files
------------

// File: rtl/led_scan_ctrl.sv
// Row-scan controller for the LED matrix with a double-buffered frame store.
// Writers fill the back bank; the front bank is scanned with blanking at both ends of every row slot.
module led_scan_ctrl #(
   parameter logic [15:0] PERIOD = 16'd27000,
   parameter logic [15:0] GAP    = 16'd500,
   parameter int          ROWS   = 9
) (
   input  logic       i_sys_clk,
   input  logic       i_rst_n,
   input  logic       i_wr_en,
   input  logic [3:0] i_wr_row,
   input  logic [7:0] i_wr_data,
   input  logic       i_swap_req,
   output logic       o_swap_pending,
   output logic       o_swap_ack,
   output logic       o_frame_start,
   output logic [8:0] o_led_row,
   output logic [7:0] o_led_col
);

   // state  | meaning
   // S_IDLE | no swap requested
   // S_PEND | swap requested, waiting for the frame boundary
   // S_DONE | banks swapped at the last boundary; ack goes out next cycle
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PEND = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [15:0] CNT_LAST = PERIOD - 16'd1;
   localparam logic [15:0] ON_END   = PERIOD - GAP;
   localparam logic [3:0]  ROW_LAST = 4'(ROWS - 1);

   logic [15:0] r_cnt;
   logic [3:0]  r_row;
   logic        r_front_sel;
   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_bank [2][ROWS];

   logic w_slot_end;
   logic w_boundary;
   logic w_swap;
   logic w_wr_ok;
   logic w_lit;

   assign w_slot_end = (r_cnt == CNT_LAST);
   assign w_boundary = w_slot_end && (r_row == ROW_LAST);
   assign w_wr_ok    = i_wr_en && (i_wr_row <= ROW_LAST);
   assign w_lit      = (r_cnt >= GAP) && (r_cnt < ON_END);

   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
         r_row <= '0;
      end else if (w_slot_end) begin
         r_cnt <= '0;
         r_row <= (r_row == ROW_LAST) ? 4'd0 : r_row + 4'd1;
      end else begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_front_sel <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_swap) begin
            r_front_sel <= ~r_front_sel;
         end
      end
   end

   // A request landing on the boundary cycle is served at that same boundary.
   always_comb begin
      w_state_nxt = r_state;
      w_swap      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_swap_req) begin
               w_state_nxt = w_boundary ? S_DONE : S_PEND;
            end
         end
         S_PEND: begin
            if (w_boundary) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = i_swap_req ? S_PEND : S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      w_swap = w_boundary && ((r_state == S_PEND) || i_swap_req);
   end

   // Writes in the boundary cycle still target the pre-swap back bank.
   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < ROWS; r++) begin
               r_bank[b][r] <= '0;
            end
         end
      end else if (w_wr_ok) begin
         r_bank[~r_front_sel][i_wr_row] <= i_wr_data;
      end
   end

   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_led_row     <= '0;
         o_led_col     <= '0;
         o_frame_start <= 1'b0;
         o_swap_ack    <= 1'b0;
      end else begin
         o_led_row     <= w_lit ? (9'd1 << r_row) : 9'd0;
         o_led_col     <= r_bank[r_front_sel][r_row];
         o_frame_start <= (r_cnt == 16'd0) && (r_row == 4'd0);
         o_swap_ack    <= (r_state == S_DONE);
      end
   end

   // Held through the swap cycle so it drops exactly when the ack appears.
   assign o_swap_pending = (r_state != S_IDLE);

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl (PERIOD=20, GAP=3, ROWS=9): scan timing, bank swaps,
// out-of-range writes, boundary-cycle requests/writes and asynchronous reset.
module tb_led_scan_ctrl;

   localparam logic [15:0] P = 16'd20;
   localparam logic [15:0] G = 16'd3;
   localparam int          R = 9;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [3:0] wr_row = 4'd0;
   logic [7:0] wr_data = 8'd0;
   logic       swap_req = 1'b0;
   logic       swap_pending;
   logic       swap_ack;
   logic       frame_start;
   logic [8:0] led_row;
   logic [7:0] led_col;

   int n_total = 0;
   int n_bad   = 0;
   int k       = 0;

   led_scan_ctrl #(.PERIOD(P), .GAP(G), .ROWS(R)) dut (
      .i_sys_clk      (clk),
      .i_rst_n        (rst_n),
      .i_wr_en        (wr_en),
      .i_wr_row       (wr_row),
      .i_wr_data      (wr_data),
      .i_swap_req     (swap_req),
      .o_swap_pending (swap_pending),
      .o_swap_ack     (swap_ack),
      .o_frame_start  (frame_start),
      .o_led_row      (led_row),
      .o_led_col      (led_col)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      k++;
   endtask

   // Front-bank contents shown for state index g, following the directed swap schedule.
   function automatic logic [7:0] exp_col(input int g);
      int row;
      row = (g / 20) % 9;
      if (g < 540)       return 8'h00;
      else if (g < 900)  return 8'(row + 1);
      else if (g < 1080) return 8'h00;
      else if (g < 1260) return 8'(row + 1);
      else if (g < 1620) return 8'h00;
      else if (row == 2) return 8'hA5;
      else               return 8'(row + 1);
   endfunction

   function automatic bit exp_ack(input int kk);
      return (kk == 541) || (kk == 901) || (kk == 1081) || (kk == 1261) || (kk == 1621);
   endfunction

   function automatic bit exp_pend(input int kk);
      return (kk >= 410 && kk <= 540) || (kk >= 723 && kk <= 900) || (kk == 1080) ||
             (kk >= 1100 && kk <= 1260) || (kk == 1620) || (kk >= 1700);
   endfunction

   task automatic check_all(input logic [7:0] ecol, input bit eack, input bit epend);
      int g;
      int cnt;
      int row;
      logic [8:0] erow;
      g    = k - 1;
      cnt  = g % 20;
      row  = (g / 20) % 9;
      erow = (cnt >= 3 && cnt < 17) ? (9'd1 << row) : 9'd0;
      chk("led_row", 32'(led_row), 32'(erow));
      chk("frame_start", 32'(frame_start), 32'((g % 180) == 0));
      chk("led_col", 32'(led_col), 32'(ecol));
      chk("swap_ack", 32'(swap_ack), 32'(eack));
      chk("swap_pending", 32'(swap_pending), 32'(epend));
   endtask

   initial begin
      int e;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_led_row", 32'(led_row), 32'd0);
      chk("rst_led_col", 32'(led_col), 32'd0);
      chk("rst_frame_start", 32'(frame_start), 32'd0);
      chk("rst_swap_ack", 32'(swap_ack), 32'd0);
      chk("rst_swap_pending", 32'(swap_pending), 32'd0);
      rst_n = 1'b1;
      k = 0;

      while (k < 1710) begin
         e = k + 1;
         wr_en    = 1'b0;
         wr_row   = 4'd0;
         wr_data  = 8'd0;
         if (e >= 401 && e <= 409) begin
            wr_en = 1'b1; wr_row = 4'(e - 401); wr_data = 8'(e - 400);
         end else if (e == 721) begin
            wr_en = 1'b1; wr_row = 4'd9; wr_data = 8'hFF;
         end else if (e == 722) begin
            wr_en = 1'b1; wr_row = 4'd15; wr_data = 8'hFF;
         end else if (e == 1620) begin
            wr_en = 1'b1; wr_row = 4'd2; wr_data = 8'hA5;
         end
         swap_req = (e == 410) || (e == 723) || (e == 1080) || (e == 1100) ||
                    (e == 1120) || (e == 1620) || (e == 1700);
         tick();
         check_all(exp_col(k - 1), exp_ack(k), exp_pend(k));
      end
      wr_en    = 1'b0;
      swap_req = 1'b0;

      // Asynchronous reset mid-frame with a swap pending.
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_led_row", 32'(led_row), 32'd0);
      chk("arst_led_col", 32'(led_col), 32'd0);
      chk("arst_frame_start", 32'(frame_start), 32'd0);
      chk("arst_swap_ack", 32'(swap_ack), 32'd0);
      chk("arst_swap_pending", 32'(swap_pending), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      k = 0;
      while (k < 200) begin
         tick();
         check_all(8'h00, 1'b0, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
